// File: rtl/updown_timer_ctrl_pkg.sv
// Shared state encoding and default parameters for the up/down timer controller.
package updown_timer_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSE   = 2'd2,
      EXPIRED = 2'd3
   } state_t;

   localparam int unsigned DEF_DEBOUNCE_CYCLES   = 1_000_000;
   localparam int unsigned DEF_DB_BITS           = 20;
   localparam int unsigned DEF_ALARM_HALF_CYCLES = 12_500_000;
   localparam int unsigned DEF_AL_BITS           = 24;

endpackage

// File: rtl/updown_timer_ctrl_key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and
// a one-cycle pulse on the accepted falling edge of the active-low key.
module key_debounce
   import updown_timer_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned DB_BITS         = DEF_DB_BITS
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic press
);

   logic               sync1;
   logic               sync2;
   logic               level;
   logic [DB_BITS-1:0] cnt;

   // Level only follows the synchronized key after it has disagreed for the full window.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         level <= 1'b1;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync1 <= key_n;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 != level) begin
            if (cnt == DB_BITS'(DEBOUNCE_CYCLES - 1)) begin
               level <= sync2;
               cnt   <= '0;
               press <= ~sync2;
            end else begin
               cnt <= cnt + DB_BITS'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/updown_timer_ctrl.sv
// Start/stop/clear sequencer for the cascaded up/down timer, with
// terminal-count detection and a blinking alarm.
module updown_timer_ctrl
   import updown_timer_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned DB_BITS           = DEF_DB_BITS,
   parameter int unsigned ALARM_HALF_CYCLES = DEF_ALARM_HALF_CYCLES,
   parameter int unsigned AL_BITS           = DEF_AL_BITS
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_start_n,
   input  logic       key_clear_n,
   input  logic       sw_up,
   input  logic       timer_zero,
   input  logic       timer_max,
   output logic       tmr_en,
   output logic       tmr_up,
   output logic       tmr_load1_n,
   output logic       tmr_load2_n,
   output logic       alarm,
   output logic [1:0] state_o
);

   state_t             state;
   logic               start_p;
   logic               clear_p;
   logic               sw_sync1;
   logic               sw_sync2;
   logic               clr_dir;
   logic               clr_go;
   logic               terminal;
   logic [AL_BITS-1:0] al_cnt;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_BITS(DB_BITS)) u_db_start (
      .clk   (clk),
      .rst   (rst),
      .key_n (key_start_n),
      .press (start_p)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_BITS(DB_BITS)) u_db_clear (
      .clk   (clk),
      .rst   (rst),
      .key_n (key_clear_n),
      .press (clear_p)
   );

   // Direction switch is a level, so it only needs metastability protection.
   always_ff @(posedge clk) begin
      if (rst) begin
         sw_sync1 <= 1'b1;
         sw_sync2 <= 1'b1;
      end else begin
         sw_sync1 <= sw_up;
         sw_sync2 <= sw_sync1;
      end
   end

   // In IDLE the live switch picks the load value; elsewhere the latched direction does.
   assign clr_dir  = (state == IDLE) ? sw_sync2 : tmr_up;
   assign clr_go   = clear_p || ((state == EXPIRED) && start_p);
   assign terminal = tmr_up ? timer_max : timer_zero;
   assign state_o  = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         tmr_en      <= 1'b0;
         tmr_up      <= 1'b0;
         tmr_load1_n <= 1'b1;
         tmr_load2_n <= 1'b1;
         alarm       <= 1'b0;
         al_cnt      <= '0;
      end else begin
         tmr_load1_n <= 1'b1;
         tmr_load2_n <= 1'b1;
         if (clr_go) begin
            tmr_load1_n <= ~clr_dir;
            tmr_load2_n <= clr_dir;
            tmr_en      <= 1'b0;
            alarm       <= 1'b0;
            al_cnt      <= '0;
            state       <= IDLE;
         end else begin
            unique case (state)
               IDLE: begin
                  if (start_p && (sw_sync2 || !timer_zero)) begin
                     tmr_up <= sw_sync2;
                     tmr_en <= 1'b1;
                     state  <= RUN;
                  end
               end
               RUN: begin
                  if (terminal) begin
                     tmr_en <= 1'b0;
                     alarm  <= 1'b1;
                     al_cnt <= '0;
                     state  <= EXPIRED;
                  end else if (start_p) begin
                     tmr_en <= 1'b0;
                     state  <= PAUSE;
                  end
               end
               PAUSE: begin
                  if (start_p) begin
                     tmr_en <= 1'b1;
                     state  <= RUN;
                  end
               end
               EXPIRED: begin
                  if (al_cnt == AL_BITS'(ALARM_HALF_CYCLES - 1)) begin
                     alarm  <= ~alarm;
                     al_cnt <= '0;
                  end else begin
                     al_cnt <= al_cnt + AL_BITS'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_updown_timer_ctrl.sv
// Scoreboard bench: stimulus queues cycle-stamped expected outputs, a monitor
// compares them on the falling edge of the matching cycle.
module tb_updown_timer_ctrl;

   typedef struct {
      int unsigned cyc;
      string       name;
      logic [6:0]  v;
      logic [6:0]  m;
   } exp_t;

   localparam logic [6:0] M_ALL  = 7'b1111111;
   localparam logic [6:0] M_NOUP = 7'b1110111;
   localparam logic [6:0] M_NOAL = 7'b1111110;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       key_start_n = 1'b1;
   logic       key_clear_n = 1'b1;
   logic       sw_up = 1'b0;
   logic       timer_zero = 1'b0;
   logic       timer_max = 1'b0;
   logic       tmr_en, tmr_up, tmr_load1_n, tmr_load2_n, alarm;
   logic [1:0] state_o;

   int unsigned cyc = 0;
   int          n_vec = 0;
   int          n_bad = 0;
   exp_t        q[$];

   updown_timer_ctrl #(
      .DEBOUNCE_CYCLES(4), .DB_BITS(8), .ALARM_HALF_CYCLES(8), .AL_BITS(8)
   ) dut (
      .clk(clk), .rst(rst), .key_start_n(key_start_n), .key_clear_n(key_clear_n),
      .sw_up(sw_up), .timer_zero(timer_zero), .timer_max(timer_max),
      .tmr_en(tmr_en), .tmr_up(tmr_up), .tmr_load1_n(tmr_load1_n),
      .tmr_load2_n(tmr_load2_n), .alarm(alarm), .state_o(state_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [6:0] ov(logic [1:0] s, logic en, logic up,
                                     logic l1, logic l2, logic al);
      return {s, en, up, l1, l2, al};
   endfunction

   // Monitor: check every expectation stamped for this cycle.
   always @(negedge clk) begin
      logic [6:0] act;
      act = {state_o, tmr_en, tmr_up, tmr_load1_n, tmr_load2_n, alarm};
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         exp_t e;
         e = q.pop_front();
         n_vec++;
         if (e.cyc != cyc || ((act ^ e.v) & e.m) != 7'b0) begin
            n_bad++;
            $display("FAIL %s cyc=%0d (due %0d) got=%b want=%b mask=%b",
                     e.name, cyc, e.cyc, act, e.v, e.m);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_at(input int unsigned c, input string nm,
                            input logic [6:0] v, input logic [6:0] m);
      exp_t e;
      e.cyc = c; e.name = nm; e.v = v; e.m = m;
      q.push_back(e);
   endtask

   task automatic expect_span(input int unsigned c0, input int unsigned c1, input string nm,
                              input logic [6:0] v, input logic [6:0] m);
      for (int unsigned c = c0; c <= c1; c++) expect_at(c, nm, v, m);
   endtask

   task automatic press(input logic s, input logic c, input int n);
      if (s) key_start_n = 1'b0;
      if (c) key_clear_n = 1'b0;
      tick(n);
      key_start_n = 1'b1;
      key_clear_n = 1'b1;
   endtask

   initial begin
      int unsigned c0;
      int unsigned c1;
      int          guard;

      // Reset held for two edges
      tick(2);
      expect_at(cyc, "reset", ov(2'd0, 0, 0, 1, 1, 0), M_ALL);
      rst = 1'b0;
      sw_up = 1'b1;

      // Three-cycle glitch must be rejected
      c0 = cyc;
      expect_span(c0 + 1, c0 + 14, "glitch_idle", ov(2'd0, 0, 0, 1, 1, 0), M_ALL);
      press(1, 0, 3);
      tick(12);

      // Real press counting up: RUN exactly 7 cycles after the edge
      c0 = cyc;
      expect_at(c0 + 6, "db_pre", ov(2'd0, 0, 0, 1, 1, 0), M_ALL);
      expect_at(c0 + 7, "db_run", ov(2'd1, 1, 1, 1, 1, 0), M_ALL);
      press(1, 0, 10);
      tick(12);

      // Pause, then resume
      c0 = cyc;
      expect_at(c0 + 6, "pause_pre", ov(2'd1, 1, 1, 1, 1, 0), M_ALL);
      expect_at(c0 + 7, "pause", ov(2'd2, 0, 1, 1, 1, 0), M_ALL);
      press(1, 0, 5);
      tick(14);
      c0 = cyc;
      expect_at(c0 + 7, "resume", ov(2'd1, 1, 1, 1, 1, 0), M_ALL);
      press(1, 0, 5);
      tick(14);

      // Simultaneous start+clear while counting up: zero load, never PAUSE
      c0 = cyc;
      expect_span(c0 + 1, c0 + 6, "both_run", ov(2'd1, 1, 1, 1, 1, 0), M_ALL);
      expect_at(c0 + 7, "both_load1", ov(2'd0, 0, 1, 0, 1, 0), M_NOUP);
      expect_span(c0 + 8, c0 + 16, "both_idle", ov(2'd0, 0, 1, 1, 1, 0), M_NOUP);
      press(1, 1, 5);
      tick(14);

      // Countdown to expiry
      sw_up = 1'b0;
      timer_zero = 1'b0;
      tick(4);
      c0 = cyc;
      expect_at(c0 + 7, "down_run", ov(2'd1, 1, 0, 1, 1, 0), M_ALL);
      press(1, 0, 5);
      tick(16);
      c1 = cyc;
      timer_zero = 1'b1;
      expect_at(c1, "pre_term", ov(2'd1, 1, 0, 1, 1, 0), M_ALL);
      expect_span(c1 + 1, c1 + 8, "alarm_hi", ov(2'd3, 0, 0, 1, 1, 1), M_ALL);
      expect_span(c1 + 9, c1 + 16, "alarm_lo", ov(2'd3, 0, 0, 1, 1, 0), M_ALL);
      expect_at(c1 + 17, "alarm_hi2", ov(2'd3, 0, 0, 1, 1, 1), M_ALL);
      tick(20);
      c0 = cyc;
      expect_at(c0 + 6, "exp_hold", ov(2'd3, 0, 0, 1, 1, 0), M_NOAL);
      expect_at(c0 + 7, "exp_load2", ov(2'd0, 0, 0, 1, 0, 0), M_ALL);
      expect_at(c0 + 8, "exp_idle", ov(2'd0, 0, 0, 1, 1, 0), M_ALL);
      press(0, 1, 5);
      tick(14);

      // Start ignored: counting down with timer already at zero
      c0 = cyc;
      expect_span(c0 + 1, c0 + 16, "zero_ign", ov(2'd0, 0, 0, 1, 1, 0), M_ALL);
      press(1, 0, 5);
      tick(14);

      // Clear in IDLE with switch up: zero load follows the live switch
      sw_up = 1'b1;
      tick(4);
      c0 = cyc;
      expect_at(c0 + 7, "idle_load1", ov(2'd0, 0, 0, 0, 1, 0), M_NOUP);
      expect_at(c0 + 8, "idle_after", ov(2'd0, 0, 0, 1, 1, 0), M_NOUP);
      press(0, 1, 5);
      tick(14);

      guard = 0;
      while (q.size() > 0 && guard < 200) begin
         tick(1);
         guard++;
      end
      if (q.size() > 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations never checked, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
